// File: rtl/id_ex_stage_pkg.sv
// Shared constants and the control bundle carried through the ID/EX register.
package id_ex_stage_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [1:0] result_src;
        logic [2:0] alu_control;
    } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_select.sv
// Operand forwarding for one source register: MEM beats WB beats the
// register-file value, and x0 is never forwarded.
module fwd_select
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic [REGW-1:0] rs,
    input  logic [REGW-1:0] rd_m,
    input  logic [REGW-1:0] rd_w,
    input  logic            reg_write_m,
    input  logic            reg_write_w,
    input  logic [XLEN-1:0] reg_val,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] result_w,
    output logic [XLEN-1:0] fwd_val
);

    logic [1:0] sel;

    always_comb begin
        sel = FWD_REG;
        if (reg_write_m && (rd_m == rs) && (rs != '0)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_w == rs) && (rs != '0)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        fwd_val = reg_val;
        unique case (sel)
            FWD_MEM: fwd_val = alu_result_m;
            FWD_WB:  fwd_val = result_w;
            default: fwd_val = reg_val;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush, operand forwarding from MEM/WB,
// branch target computation and redirect resolution.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] imm_ext_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic [REGW-1:0] rs1_d,
    input  logic [REGW-1:0] rs2_d,
    input  logic [REGW-1:0] rd_d,
    input  logic            reg_write_d,
    input  logic            mem_write_d,
    input  logic            branch_d,
    input  logic            jump_d,
    input  logic            alu_src_d,
    input  logic [1:0]      result_src_d,
    input  logic [2:0]      alu_control_d,
    input  logic [REGW-1:0] rd_m,
    input  logic [REGW-1:0] rd_w,
    input  logic            reg_write_m,
    input  logic            reg_write_w,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] result_w,
    input  logic            zero_e,
    output logic [XLEN-1:0] src_a_e,
    output logic [XLEN-1:0] src_b_e,
    output logic [2:0]      alu_control_e,
    output logic [XLEN-1:0] write_data_e,
    output logic [REGW-1:0] rd_e,
    output logic [REGW-1:0] rs1_e,
    output logic [REGW-1:0] rs2_e,
    output logic            reg_write_e,
    output logic            mem_write_e,
    output logic [1:0]      result_src_e,
    output logic [XLEN-1:0] pc_plus4_e,
    output logic [XLEN-1:0] pc_target_e,
    output logic            pc_src_e
);

    id_ex_ctrl_t     ctrl_in, ctrl_q;
    logic [XLEN-1:0] rd1_q, rd2_q, imm_q, pc_q, pc_plus4_q;
    logic [REGW-1:0] rs1_q, rs2_q, rd_q;

    assign ctrl_in = '{
        reg_write:   reg_write_d,
        mem_write:   mem_write_d,
        branch:      branch_d,
        jump:        jump_d,
        alu_src:     alu_src_d,
        result_src:  result_src_d,
        alu_control: alu_control_d
    };

    // Data fields are cleared on flush too, so a bubble never carries stale operands.
    always_ff @(posedge clk) begin
        if (rst || flush_e) begin
            ctrl_q     <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else if (!stall_e) begin
            ctrl_q     <= ctrl_in;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_ext_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
        end
    end

    fwd_select #(
        .XLEN (XLEN),
        .REGW (REGW)
    ) u_fwd_a (
        .rs           (rs1_q),
        .rd_m         (rd_m),
        .rd_w         (rd_w),
        .reg_write_m  (reg_write_m),
        .reg_write_w  (reg_write_w),
        .reg_val      (rd1_q),
        .alu_result_m (alu_result_m),
        .result_w     (result_w),
        .fwd_val      (src_a_e)
    );

    fwd_select #(
        .XLEN (XLEN),
        .REGW (REGW)
    ) u_fwd_b (
        .rs           (rs2_q),
        .rd_m         (rd_m),
        .rd_w         (rd_w),
        .reg_write_m  (reg_write_m),
        .reg_write_w  (reg_write_w),
        .reg_val      (rd2_q),
        .alu_result_m (alu_result_m),
        .result_w     (result_w),
        .fwd_val      (write_data_e)
    );

    assign src_b_e       = ctrl_q.alu_src ? imm_q : write_data_e;
    assign alu_control_e = ctrl_q.alu_control;
    assign rd_e          = rd_q;
    assign rs1_e         = rs1_q;
    assign rs2_e         = rs2_q;
    assign reg_write_e   = ctrl_q.reg_write;
    assign mem_write_e   = ctrl_q.mem_write;
    assign result_src_e  = ctrl_q.result_src;
    assign pc_plus4_e    = pc_plus4_q;
    assign pc_target_e   = pc_q + imm_q;
    assign pc_src_e      = (ctrl_q.branch & zero_e) | ctrl_q.jump;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-forwarding front end of the execute stage. It captures decoded instruction fields and control from decode each cycle, applies stall and flush, and selects forwarded operands from MEM/WB. Its outputs drive the ALU operand and control inputs. It also resolves branch/jump redirection from the ALU zero flag.

## Interface
- XLEN, 32, datapath width
- REGW, 5, register-address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall_e  in  1  hold all ID/EX registers
- flush_e  in  1  load bubble into ID/EX
- rd1_d, rd2_d  in  XLEN  register-file read data from decode
- imm_ext_d, pc_d, pc_plus4_d  in  XLEN  extended immediate, PC, PC+4
- rs1_d, rs2_d, rd_d  in  REGW  source and destination addresses
- reg_write_d, mem_write_d, branch_d, jump_d, alu_src_d  in  1 each  decoded control
- result_src_d  in  2  writeback select (00 ALU, 01 mem, 10 PC+4)
- alu_control_d  in  3  ALU op code
- rd_m, rd_w  in  REGW  destinations in MEM and WB
- reg_write_m, reg_write_w  in  1  write enables in MEM and WB
- alu_result_m, result_w  in  XLEN  forwardable values
- zero_e  in  1  ALU zero flag, same cycle
- src_a_e, src_b_e  out  XLEN  ALU operands
- alu_control_e  out  3  ALU op code
- write_data_e  out  XLEN  forwarded rs2 value for stores
- rd_e, rs1_e, rs2_e  out  REGW  registered addresses for the hazard unit
- reg_write_e, mem_write_e  out  1  registered control
- result_src_e  out  2  registered writeback select
- pc_plus4_e  out  XLEN  registered PC+4
- pc_target_e  out  XLEN  pc_e + imm_e
- pc_src_e  out  1  redirect: (branch_e & zero_e) | jump_e

## Operation
- Register update per rising edge, priority: rst > flush_e > stall_e > load.
  - rst or flush_e: all control fields (reg_write, mem_write, branch, jump, alu_src, result_src, alu_control) and rd/rs1/rs2 cleared to 0. Data fields cleared on rst; on flush they are don't-care but must be cleared.
  - stall_e (no flush): all fields hold.
  - Otherwise: all *_d inputs captured.
- Forwarding for operand A (rs1_e), then the same rule for B (rs2_e):
  - 10 if reg_write_m & rd_m == rs1_e & rs1_e != 0: use alu_result_m.
  - else 01 if reg_write_w & rd_w == rs1_e & rs1_e != 0: use result_w.
  - else 00: use the registered rd1.
  - MEM has priority over WB.
- write_data_e is the forwarded B value. src_b_e = alu_src_e ? imm_e : write_data_e. src_a_e is the forwarded A value.
- pc_target_e uses XLEN-bit modulo addition; overflow wraps.
- pc_src_e is combinational from the registered branch_e/jump_e and the same-cycle zero_e. A bubble yields 0.
- The block does not generate stall or flush itself. The load-use and redirect flush decisions belong to the hazard unit.

## Timing
- Latency: 1 cycle from *_d to the registered *_e outputs.
- Forwarding muxes, src_a_e/src_b_e, pc_target_e and pc_src_e are combinational from registers and same-cycle MEM/WB/zero inputs. There is no extra cycle.
- Reset values: every registered output is 0. src_a_e and src_b_e are 0 unless forwarding is active (MEM/WB inputs are also under reset). alu_control_e = 000 (add). pc_src_e = 0.
- Simultaneous stall_e and flush_e: the flush wins.
- rst during a stall: the registers clear in that cycle.
- An x0 destination never forwards, even with reg_write set.

## Structure
- A shared package holds:
  - the ALU op constants: ALU_ADD 000, ALU_SUB 001, ALU_AND 010, ALU_OR 011, ALU_SLT 101.
  - the result_src constants.
  - the forward-select constants FWD_REG 00, FWD_WB 01, FWD_MEM 10.
  - an id_ex_ctrl_t packed struct for the control bundle.
- One sub-module, fwd_select: a combinational comparator and 3:1 mux, instantiated twice (A and B).

## Test plan
- Plain load: rd1_d=5, rd2_d=7, alu_control_d=000, alu_src_d=0, no hazards. One edge later: src_a_e=5, src_b_e=7, alu_control_e=000.
- MEM-over-WB priority: rs1_e=3, rd_m=rd_w=3, both write enables set, alu_result_m=0xAA, result_w=0xBB. Required: src_a_e=0xAA. Drop reg_write_m: src_a_e=0xBB.
- x0 guard: rs2_e=0, rd_m=0, reg_write_m=1, alu_result_m=0xFF, rd2 registered as 0x12. Required: write_data_e=0x12.
- Stall then flush: load reg_write_d=1, then assert stall_e with changed inputs. Outputs hold. Then assert stall_e and flush_e together: reg_write_e=0, mem_write_e=0, pc_src_e=0.
- Branch: branch_d=1, pc_d=0x100, imm_ext_d=0xFFFFFFF8. After the edge: pc_target_e=0xF8, and pc_src_e follows zero_e (0 to 0, 1 to 1).
- Jump with wrap: jump_d=1, pc_d=0xFFFFFFFC, imm_ext_d=8. Required: pc_target_e=0x4 and pc_src_e=1 regardless of zero_e.
